// File: rtl/sma_stream_scheduler.sv
// rtl/sma_stream_scheduler.sv - round-robin time-shared moving-average / trade-signal engine for NUM_CH price streams
// Optional build macro: SMA_ROUND_EN (round-half-up SMA with saturation instead of truncation)
module sma_stream_scheduler #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int BUFFER_SIZE = 4,
  parameter  int NUM_CH      = 4,
  localparam int CH_W        = $clog2(NUM_CH),
  localparam int SUM_WIDTH   = DATA_WIDTH + $clog2(BUFFER_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_W-1:0]              out_ch,
  output logic [DATA_WIDTH-1:0]        out_price,
  output logic [DATA_WIDTH-1:0]        out_sma,
  output logic                         out_full,
  output logic [1:0]                   out_signal
);

  localparam int LOG2B = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUFFER_SIZE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  win  [NUM_CH][BUFFER_SIZE];
  logic [SUM_WIDTH-1:0]   sum  [NUM_CH];
  logic [LOG2B-1:0]       wptr [NUM_CH];
  logic [CNT_W-1:0]       cnt  [NUM_CH];

  logic [CH_W-1:0]        last_grant;
  logic [CH_W-1:0]        cur_ch;
  logic [DATA_WIDTH-1:0]  cur_price;

  logic [CH_W-1:0]        grant;
  logic                   grant_found;
  logic [DATA_WIDTH-1:0]  grant_data;

  logic [SUM_WIDTH-1:0]   new_sum;
  logic [DATA_WIDTH-1:0]  new_sma;
  logic                   new_full;
  logic [1:0]             new_signal;

  // Channel index 'offset' positions after the one just past base, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int offset);
    int t;
    t = int'(base) + 1 + offset;
    if (t >= NUM_CH) t = t - NUM_CH;
    return CH_W'(t);
  endfunction

  // Round-robin search: first valid channel after the last one served.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && in_valid[rr_index(last_grant, i)]) begin
        grant       = rr_index(last_grant, i);
        grant_found = 1'b1;
      end
    end
  end

  assign grant_data = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

  // One-hot accept toward the granted channel, only while idle and out of reset.
  always_comb begin
    in_ready = '0;
    if (!rst && state == IDLE && grant_found) in_ready[grant] = 1'b1;
  end

`ifdef SMA_ROUND_EN
  localparam logic [SUM_WIDTH:0] HALF  = (SUM_WIDTH+1)'(1 << (LOG2B - 1));
  localparam logic [SUM_WIDTH:0] MAX_V = (SUM_WIDTH+1)'((1 << DATA_WIDTH) - 1);
  logic [SUM_WIDTH:0] rnd_q;
`endif

  // Read-modify-write arithmetic for the channel being served; evict oldest slot, add new sample.
  always_comb begin
    new_sum = sum[cur_ch] - SUM_WIDTH'(win[cur_ch][wptr[cur_ch]]) + SUM_WIDTH'(cur_price);
`ifdef SMA_ROUND_EN
    rnd_q   = ({1'b0, new_sum} + HALF) >> LOG2B;
    new_sma = (rnd_q > MAX_V) ? {DATA_WIDTH{1'b1}} : DATA_WIDTH'(rnd_q);
`else
    new_sma = DATA_WIDTH'(new_sum >> LOG2B);
`endif
    new_full = (cnt[cur_ch] >= CNT_LAST);
    if (!new_full)                new_signal = 2'b00;
    else if (cur_price > new_sma) new_signal = 2'b01;
    else if (cur_price < new_sma) new_signal = 2'b10;
    else                          new_signal = 2'b00;
  end

  // Sequencer FSM with per-channel window storage and registered result port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= CH_W'(NUM_CH - 1);
      cur_ch     <= '0;
      cur_price  <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_price  <= '0;
      out_sma    <= '0;
      out_full   <= 1'b0;
      out_signal <= 2'b00;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c]  <= '0;
        wptr[c] <= '0;
        cnt[c]  <= '0;
        for (int b = 0; b < BUFFER_SIZE; b++) win[c][b] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cur_ch     <= grant;
            cur_price  <= grant_data;
            last_grant <= grant;
            state      <= CALC;
          end
        end
        CALC: begin
          win[cur_ch][wptr[cur_ch]] <= cur_price;
          sum[cur_ch]  <= new_sum;
          wptr[cur_ch] <= wptr[cur_ch] + 1'b1;
          if (cnt[cur_ch] != CNT_MAX) cnt[cur_ch] <= cnt[cur_ch] + 1'b1;
          out_valid  <= 1'b1;
          out_ch     <= cur_ch;
          out_price  <= cur_price;
          out_sma    <= new_sma;
          out_full   <= new_full;
          out_signal <= new_signal;
          state      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sma_stream_scheduler.sv
// tb/tb_sma_stream_scheduler.sv - self-checking bench for sma_stream_scheduler (directed plan plus random traffic)
module tb_sma_stream_scheduler;

  localparam int DW   = 8;
  localparam int BS   = 4;
  localparam int NCH  = 2;
  localparam int NLIT = 23;

  localparam int LIT_CH    [NLIT] = '{0,0,0,0,0, 0,1,0,1,0,1,0,1, 0,1, 0,0,0,0, 1,1,1,1};
  localparam int LIT_PRICE [NLIT] = '{10,20,30,40,0, 8,4,8,4,8,4,8,4, 200,100, 10,20,30,100, 50,50,50,50};
  localparam int LIT_FULL  [NLIT] = '{0,0,0,1,1, 0,0,0,0,0,0,1,1, 1,1, 0,0,0,0, 0,0,0,1};
  localparam int LIT_SIG   [NLIT] = '{0,0,0,1,2, 0,0,0,0,0,0,0,0, 1,1, 0,0,0,0, 0,0,0,0};
`ifdef SMA_ROUND_EN
  localparam int LIT_SMA   [NLIT] = '{3,8,15,25,23, 2,1,4,2,6,3,8,4, 56,28, 3,8,15,25, 13,25,38,50};
`else
  localparam int LIT_SMA   [NLIT] = '{2,7,15,25,22, 2,1,4,2,6,3,8,4, 56,28, 2,7,15,25, 12,25,37,50};
`endif

  logic              clk;
  logic              rst;
  logic              v0, v1;
  logic [DW-1:0]     d0, d1;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              out_ch;
  logic [DW-1:0]     out_price;
  logic [DW-1:0]     out_sma;
  logic              out_full;
  logic [1:0]        out_signal;

  assign in_valid = {v1, v0};
  assign in_data  = {d1, d0};

  sma_stream_scheduler #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_price(out_price), .out_sma(out_sma), .out_full(out_full), .out_signal(out_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model and compare process: sliding-window history per channel, evaluated each falling edge.
  int hist [NCH][$];
  int m_phase, m_last, n_log;
  int e_ch, e_price, e_sma, e_full, e_sig;
  int g, c, s, exp_rdy;

  initial begin
    m_phase = 0; m_last = NCH - 1; n_log = 0;
    e_ch = 0; e_price = 0; e_sma = 0; e_full = 0; e_sig = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_fields", int'({out_ch, out_price, out_sma, out_full, out_signal}), 0);
        m_phase = 0;
        m_last  = NCH - 1;
        for (int k = 0; k < NCH; k++) hist[k].delete();
      end else begin
        g = -1;
        if (m_phase == 0) begin
          for (int i = 0; i < NCH; i++) begin
            c = (m_last + 1 + i) % NCH;
            if (g < 0 && in_valid[c]) g = c;
          end
        end
        exp_rdy = (g >= 0) ? (1 << g) : 0;
        chk("in_ready", int'(in_ready), exp_rdy);
        chk("out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
        if (m_phase == 2) begin
          chk("out_ch", int'(out_ch), e_ch);
          chk("out_price", int'(out_price), e_price);
          chk("out_sma", int'(out_sma), e_sma);
          chk("out_full", int'(out_full), e_full);
          chk("out_signal", int'(out_signal), e_sig);
        end
        if (m_phase == 0 && g >= 0) begin
          e_ch    = g;
          e_price = int'(in_data[g*DW +: DW]);
          hist[g].push_back(e_price);
          if (hist[g].size() > BS) void'(hist[g].pop_front());
          s = 0;
          for (int k = 0; k < hist[g].size(); k++) s += hist[g][k];
`ifdef SMA_ROUND_EN
          e_sma = (s + BS/2) / BS;
          if (e_sma > 255) e_sma = 255;
`else
          e_sma = s / BS;
`endif
          e_full = (hist[g].size() == BS) ? 1 : 0;
          if (e_full == 0)           e_sig = 0;
          else if (e_price > e_sma)  e_sig = 1;
          else if (e_price < e_sma)  e_sig = 2;
          else                       e_sig = 0;
          if (n_log < NLIT) begin
            chk("lit_ch", e_ch, LIT_CH[n_log]);
            chk("lit_price", e_price, LIT_PRICE[n_log]);
            chk("lit_sma", e_sma, LIT_SMA[n_log]);
            chk("lit_full", e_full, LIT_FULL[n_log]);
            chk("lit_signal", e_sig, LIT_SIG[n_log]);
          end
          n_log++;
          m_last  = g;
          m_phase = 1;
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (m_phase == 2 && out_ready) begin
          m_phase = 0;
        end
      end
    end
  end

  // Stimulus
  int q0[$];
  int q1[$];

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic feed(input int gap, input int rmode, input int stall, input int budget);
    int hs, target, cyc, stl;
    logic a0, a1;
    hs = 0; cyc = 0; stl = stall; a0 = 1'b0; a1 = 1'b0;
    target = q0.size() + q1.size();
    while (hs < target && cyc < budget) begin
      @(posedge clk); #2;
      if (a0) v0 = 1'b0;
      if (a1) v1 = 1'b0;
      if (!v0 && q0.size() > 0 && $urandom_range(99) >= gap) begin d0 = DW'(q0.pop_front()); v0 = 1'b1; end
      if (!v1 && q1.size() > 0 && $urandom_range(99) >= gap) begin d1 = DW'(q1.pop_front()); v1 = 1'b1; end
      if (stl > 0)       out_ready = 1'b0;
      else if (rmode != 0) out_ready = 1'($urandom_range(1));
      else               out_ready = 1'b1;
      @(negedge clk);
      a0 = in_ready[0];
      a1 = in_ready[1];
      if (out_valid && out_ready) hs++;
      if (out_valid && stl > 0) stl--;
      cyc++;
    end
    if (hs < target) begin
      $display("FAIL feed_timeout: got %0d handshakes expected %0d", hs, target);
      $fatal(1, "feed timeout");
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;

    q0 = '{10, 20, 30, 40, 0};
    feed(0, 0, 0, 200);

    do_reset();
    q0 = '{8, 8, 8, 8};
    q1 = '{4, 4, 4, 4};
    feed(0, 0, 0, 200);

    q0 = '{200};
    q1 = '{100};
    feed(0, 0, 5, 200);

    do_reset();
    q0 = '{10, 20};
    feed(0, 0, 0, 200);
    @(posedge clk); #2;
    d0 = 8'd30; v0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[0] && n < 20);
    if (!in_ready[0]) begin
      $display("FAIL accept_timeout: got in_ready %0d expected 1", in_ready);
      $fatal(1, "accept timeout");
    end
    @(posedge clk); #2;
    v0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    q0 = '{100};
    feed(0, 0, 0, 200);

    q1 = '{50, 50, 50, 50};
    feed(0, 0, 0, 200);

    do_reset();
    n = int'($urandom_range(60, 100));
    for (int i = 0; i < n; i++) q0.push_back(int'($urandom_range(255)));
    n = int'($urandom_range(60, 100));
    for (int i = 0; i < n; i++) q1.push_back(int'($urandom_range(255)));
    feed(40, 1, 0, 20000);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
